controlador_banco: RTL and testbench

Controller that shares the 32x16 register bank between a read client (two operands per request) and a write client. The bank performs either a dual read or a single write per cycle (RW bit) with registered read outputs. The controller holds writes in a small FIFO, schedules bank cycles between the two clients with anti-starvation, and forwards buffered data so reads always observe earlier writes. It sits between the datapath/pipeline clients and the register bank.

---
 rtl/controlador_banco_pkg.sv | 20 ++
 rtl/controlador_banco_buffer_escrita.sv | 84 ++++++++
 rtl/controlador_banco.sv | 152 +++++++++++++++
 tb/tb_controlador_banco.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_banco_pkg.sv
// Shared definitions for the register-bank controller.
//   LARG_END   : bank address width as seen on the bank ports
//   LARG_IDX   : significant register index width (32 registers)
//   LARG_DADO  : data width
//   RW_LEITURA / RW_ESCRITA : bank RW encoding
//   end_banco() : widens a register index to a bank address with MSB forced to 0
package controlador_banco_pkg;

    localparam int LARG_END  = 6;
    localparam int LARG_IDX  = 5;
    localparam int LARG_DADO = 16;

    localparam logic RW_LEITURA = 1'b0;
    localparam logic RW_ESCRITA = 1'b1;

    function automatic logic [LARG_END-1:0] end_banco(input logic [LARG_IDX-1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/controlador_banco_buffer_escrita.sv
// Write buffer: synchronous FIFO of {register index, data}.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (empties the FIFO)
//   push, push_addr/dado  enqueue request and entry contents
//   pop                   dequeue the head entry
//   full, empty, count    occupancy
//   ent_addr/dado/valid   every entry in age order: index 0 is the head (oldest),
//                         higher indices are younger; valid marks occupied slots
module controlador_banco_buffer_escrita
    import controlador_banco_pkg::*;
#(
    parameter int PROFUNDIDADE = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      push,
    input  logic [LARG_IDX-1:0]                       push_addr,
    input  logic [LARG_DADO-1:0]                      push_dado,
    input  logic                                      pop,
    output logic                                      full,
    output logic                                      empty,
    output logic [$clog2(PROFUNDIDADE):0]             count,
    output logic [PROFUNDIDADE-1:0][LARG_IDX-1:0]     ent_addr,
    output logic [PROFUNDIDADE-1:0][LARG_DADO-1:0]    ent_dado,
    output logic [PROFUNDIDADE-1:0]                   ent_valid
);

    localparam int LP = $clog2(PROFUNDIDADE);

    logic [PROFUNDIDADE-1:0][LARG_IDX-1:0]  mem_addr;
    logic [PROFUNDIDADE-1:0][LARG_DADO-1:0] mem_dado;
    logic [LP-1:0]                          wr_ptr;
    logic [LP-1:0]                          rd_ptr;
    logic [LP:0]                            count_q;
    logic                                   push_ok;
    logic                                   pop_ok;

    assign full    = (count_q == (LP+1)'(PROFUNDIDADE));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            mem_addr <= '0;
            mem_dado <= '0;
        end else begin
            if (push_ok) begin
                mem_addr[wr_ptr] <= push_addr;
                mem_dado[wr_ptr] <= push_dado;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Rotate storage into age order so the consumer can pick the youngest
    // match simply by scanning upward.
    always_comb begin
        logic [LP-1:0] idx;
        ent_addr  = '0;
        ent_dado  = '0;
        ent_valid = '0;
        idx       = '0;
        for (int k = 0; k < PROFUNDIDADE; k++) begin
            idx          = rd_ptr + LP'(k);
            ent_addr[k]  = mem_addr[idx];
            ent_dado[k]  = mem_dado[idx];
            ent_valid[k] = ((LP+1)'(k) < count_q);
        end
    end

endmodule

// File: rtl/controlador_banco.sv
// Register-bank controller: shares a 32x16 bank (dual read or single write per
// cycle, registered read outputs) between a two-operand read client and a
// buffered write client, with anti-starvation and read-after-write forwarding.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_req, rd_addr_a/b             read request (held until rd_ack) and operands
//   rd_ack                          read issued this cycle (combinational)
//   rd_valid, rd_dado_a/b           read result, one cycle after rd_ack
//   wr_req, wr_addr, wr_dado        write request (held until wr_ack)
//   wr_ack                          write accepted into the buffer (combinational)
//   buffer_vazio                    no pending writes
//   banco_regA/B/C, banco_dado,
//   banco_RW                        bank command
//   banco_saidaA/B                  bank registered read data
module controlador_banco
    import controlador_banco_pkg::*;
#(
    parameter int PROFUNDIDADE  = 2,
    parameter int LIMITE_ESPERA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req,
    input  logic [LARG_END-1:0]  rd_addr_a,
    input  logic [LARG_END-1:0]  rd_addr_b,
    output logic                 rd_ack,
    output logic                 rd_valid,
    output logic [LARG_DADO-1:0] rd_dado_a,
    output logic [LARG_DADO-1:0] rd_dado_b,
    input  logic                 wr_req,
    input  logic [LARG_END-1:0]  wr_addr,
    input  logic [LARG_DADO-1:0] wr_dado,
    output logic                 wr_ack,
    output logic                 buffer_vazio,
    output logic [LARG_END-1:0]  banco_regA,
    output logic [LARG_END-1:0]  banco_regB,
    output logic [LARG_END-1:0]  banco_regC,
    output logic [LARG_DADO-1:0] banco_dado,
    output logic                 banco_RW,
    input  logic [LARG_DADO-1:0] banco_saidaA,
    input  logic [LARG_DADO-1:0] banco_saidaB
);

    localparam int LC = $clog2(LIMITE_ESPERA + 1);

    logic                                   full;
    logic                                   empty;
    logic [$clog2(PROFUNDIDADE):0]          count;
    logic [PROFUNDIDADE-1:0][LARG_IDX-1:0]  ent_addr;
    logic [PROFUNDIDADE-1:0][LARG_DADO-1:0] ent_dado;
    logic [PROFUNDIDADE-1:0]                ent_valid;

    logic                 emite_escrita;
    logic                 emite_leitura;
    logic                 achou_a;
    logic                 achou_b;
    logic [LARG_DADO-1:0] fwd_dado_a;
    logic [LARG_DADO-1:0] fwd_dado_b;

    // Remaining reads a pending write may still yield to; zero forces the write.
    logic [LC-1:0]        credito;
    logic                 fwd_a_q;
    logic                 fwd_b_q;
    logic [LARG_DADO-1:0] fwd_dado_a_q;
    logic [LARG_DADO-1:0] fwd_dado_b_q;

    // Address bit 5 carries no meaning for a 32-entry bank.
    logic unused_msb;
    assign unused_msb = ^{rd_addr_a[LARG_END-1], rd_addr_b[LARG_END-1], wr_addr[LARG_END-1]};

    controlador_banco_buffer_escrita #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_ack),
        .push_addr (wr_addr[LARG_IDX-1:0]),
        .push_dado (wr_dado),
        .pop       (emite_escrita),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ent_addr  (ent_addr),
        .ent_dado  (ent_dado),
        .ent_valid (ent_valid)
    );

    // Scheduler. rst_n gates the handshakes so nothing is acknowledged while
    // the block is held in reset. A full buffer refuses a push even if it
    // drains in the same cycle.
    always_comb begin
        emite_escrita = rst_n && !empty && (!rd_req || full || (credito == '0));
        emite_leitura = rst_n && !emite_escrita && rd_req;
        rd_ack        = emite_leitura;
        wr_ack        = rst_n && wr_req && !full;
        banco_RW      = emite_escrita ? RW_ESCRITA : RW_LEITURA;
        banco_regA    = end_banco(rd_addr_a[LARG_IDX-1:0]);
        banco_regB    = end_banco(rd_addr_b[LARG_IDX-1:0]);
        banco_regC    = end_banco(ent_addr[0]);
        banco_dado    = ent_dado[0];
    end

    // Forwarding search. Entries are in age order, so the last hit is the
    // youngest. A write pushed this cycle is not yet in storage and is
    // therefore naturally excluded.
    always_comb begin
        achou_a    = 1'b0;
        achou_b    = 1'b0;
        fwd_dado_a = '0;
        fwd_dado_b = '0;
        for (int k = 0; k < PROFUNDIDADE; k++) begin
            if (ent_valid[k] && (ent_addr[k] == rd_addr_a[LARG_IDX-1:0])) begin
                achou_a    = 1'b1;
                fwd_dado_a = ent_dado[k];
            end
            if (ent_valid[k] && (ent_addr[k] == rd_addr_b[LARG_IDX-1:0])) begin
                achou_b    = 1'b1;
                fwd_dado_b = ent_dado[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid     <= 1'b0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_dado_a_q <= '0;
            fwd_dado_b_q <= '0;
            credito      <= LC'(LIMITE_ESPERA);
        end else begin
            rd_valid <= emite_leitura;
            if (emite_leitura) begin
                fwd_a_q      <= achou_a;
                fwd_b_q      <= achou_b;
                fwd_dado_a_q <= fwd_dado_a;
                fwd_dado_b_q <= fwd_dado_b;
            end
            // Only reads that overtake a pending write consume credit.
            if (emite_escrita || empty) begin
                credito <= LC'(LIMITE_ESPERA);
            end else if (emite_leitura && (credito != '0)) begin
                credito <= credito - 1'b1;
            end
        end
    end

    assign rd_dado_a    = rd_valid ? (fwd_a_q ? fwd_dado_a_q : banco_saidaA) : '0;
    assign rd_dado_b    = rd_valid ? (fwd_b_q ? fwd_dado_b_q : banco_saidaB) : '0;
    assign buffer_vazio = (count == '0);

endmodule

// File: tb/tb_controlador_banco.sv
module tb_controlador_banco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [5:0]  rd_addr_a;
    logic [5:0]  rd_addr_b;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_dado_a;
    logic [15:0] rd_dado_b;
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [15:0] wr_dado;
    logic        wr_ack;
    logic        buffer_vazio;
    logic [5:0]  banco_regA;
    logic [5:0]  banco_regB;
    logic [5:0]  banco_regC;
    logic [15:0] banco_dado;
    logic        banco_RW;
    logic [15:0] banco_saidaA;
    logic [15:0] banco_saidaB;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controlador_banco #(
        .PROFUNDIDADE  (2),
        .LIMITE_ESPERA (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_dado_a    (rd_dado_a),
        .rd_dado_b    (rd_dado_b),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_dado      (wr_dado),
        .wr_ack       (wr_ack),
        .buffer_vazio (buffer_vazio),
        .banco_regA   (banco_regA),
        .banco_regB   (banco_regB),
        .banco_regC   (banco_regC),
        .banco_dado   (banco_dado),
        .banco_RW     (banco_RW),
        .banco_saidaA (banco_saidaA),
        .banco_saidaB (banco_saidaB)
    );

    // Register bank stand-in: register i starts at 0xB000+i.
    logic [15:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hB000 + 16'(i);
        banco_saidaA = 16'h0;
        banco_saidaB = 16'h0;
    end
    always @(posedge clk) begin
        if (banco_RW) begin
            mem[banco_regC[4:0]] <= banco_dado;
        end else begin
            banco_saidaA <= mem[banco_regA[4:0]];
            banco_saidaB <= mem[banco_regB[4:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_req = 1'b0; wr_addr = '0; wr_dado = '0;

        // Held in reset with both requests raised
        tick(); tick();
        rd_req = 1'b1; wr_req = 1'b1; wr_addr = 6'd3;
        #1;
        chk("rst_rd_ack", 32'(rd_ack), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        chk("rst_rw", 32'(banco_RW), 0);
        chk("rst_vazio", 32'(buffer_vazio), 1);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_dado_a", 32'(rd_dado_a), 0);
        rd_req = 1'b0; wr_req = 1'b0;
        rst_n = 1'b1;

        // Idle
        tick(); #1;
        chk("idle_rd_valid", 32'(rd_valid), 0);
        chk("idle_rw", 32'(banco_RW), 0);
        chk("idle_vazio", 32'(buffer_vazio), 1);
        chk("idle_dado_a", 32'(rd_dado_a), 0);
        chk("idle_dado_b", 32'(rd_dado_b), 0);

        // Single write, address bit 5 set (0x25 -> r5)
        wr_req = 1'b1; wr_addr = 6'h25; wr_dado = 16'h1234;
        #1;
        chk("w1_wr_ack", 32'(wr_ack), 1);
        chk("w1_rw_t", 32'(banco_RW), 0);
        tick(); wr_req = 1'b0; #1;
        chk("w1_rw", 32'(banco_RW), 1);
        chk("w1_regC", 32'(banco_regC), 32'h05);
        chk("w1_dado", 32'(banco_dado), 32'h1234);
        chk("w1_vazio_t1", 32'(buffer_vazio), 0);
        tick(); #1;
        chk("w1_vazio_t2", 32'(buffer_vazio), 1);
        chk("w1_rw_t2", 32'(banco_RW), 0);

        // Write r7 then read r7/r3: write deferred, r7 forwarded
        wr_req = 1'b1; wr_addr = 6'd7; wr_dado = 16'hAAAA;
        #1;
        chk("w2_wr_ack", 32'(wr_ack), 1);
        tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr_a = 6'd7; rd_addr_b = 6'd3; #1;
        chk("r2_ack", 32'(rd_ack), 1);
        chk("r2_rw", 32'(banco_RW), 0);
        chk("r2_regA", 32'(banco_regA), 7);
        chk("r2_regB", 32'(banco_regB), 3);
        tick(); rd_req = 1'b0; #1;
        chk("r2_valid", 32'(rd_valid), 1);
        chk("r2_fwd_a", 32'(rd_dado_a), 32'hAAAA);
        chk("r2_bank_b", 32'(rd_dado_b), 32'hB003);
        chk("r2_drain_rw", 32'(banco_RW), 1);
        chk("r2_drain_regC", 32'(banco_regC), 7);
        tick(); #1;
        chk("r2_valid_off", 32'(rd_valid), 0);
        chk("r2_dado_zero", 32'(rd_dado_a), 0);
        chk("r2_vazio", 32'(buffer_vazio), 1);

        // Two writes to r9 under reads; full buffer forces a write
        wr_req = 1'b1; wr_addr = 6'd9; wr_dado = 16'h0001;
        rd_req = 1'b1; rd_addr_a = 6'd0; rd_addr_b = 6'd0;
        #1;
        chk("u0_rd_ack", 32'(rd_ack), 1);
        chk("u0_wr_ack", 32'(wr_ack), 1);
        tick(); wr_dado = 16'h0002; rd_addr_a = 6'd9; rd_addr_b = 6'd9; #1;
        chk("u1_rd_ack", 32'(rd_ack), 1);
        chk("u1_wr_ack", 32'(wr_ack), 1);
        chk("u1_valid", 32'(rd_valid), 1);
        chk("u1_dado_a", 32'(rd_dado_a), 32'hB000);
        tick(); wr_addr = 6'd11; wr_dado = 16'h5555; #1;
        chk("u2_full_wr_ack", 32'(wr_ack), 0);
        chk("u2_rd_ack", 32'(rd_ack), 0);
        chk("u2_rw", 32'(banco_RW), 1);
        chk("u2_regC", 32'(banco_regC), 9);
        chk("u2_dado", 32'(banco_dado), 32'h0001);
        chk("u2_excl_a", 32'(rd_dado_a), 32'h0001);
        chk("u2_excl_b", 32'(rd_dado_b), 32'h0001);
        tick(); #1;
        chk("u3_wr_ack", 32'(wr_ack), 1);
        chk("u3_rd_ack", 32'(rd_ack), 1);
        chk("u3_valid", 32'(rd_valid), 0);
        chk("u3_dado_a", 32'(rd_dado_a), 0);
        tick(); wr_req = 1'b0; #1;
        chk("u4_rw", 32'(banco_RW), 1);
        chk("u4_dado", 32'(banco_dado), 32'h0002);
        chk("u4_rd_ack", 32'(rd_ack), 0);
        chk("u4_young_a", 32'(rd_dado_a), 32'h0002);
        chk("u4_young_b", 32'(rd_dado_b), 32'h0002);

        // Starvation: r11 pending, reads held -> 4 acks then forced write
        tick(); rd_addr_a = 6'd11; rd_addr_b = 6'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_ack", 32'(rd_ack), 1);
            chk("starve_rw", 32'(banco_RW), 0);
            if (i > 0) begin
                chk("starve_fwd_a", 32'(rd_dado_a), 32'h5555);
                chk("starve_bank_b", 32'(rd_dado_b), 32'h1234);
            end
            tick();
        end
        #1;
        chk("forced_rw", 32'(banco_RW), 1);
        chk("forced_rd_ack", 32'(rd_ack), 0);
        chk("forced_regC", 32'(banco_regC), 11);
        chk("forced_dado", 32'(banco_dado), 32'h5555);
        chk("forced_valid", 32'(rd_valid), 1);
        tick(); #1;
        chk("resume_ack", 32'(rd_ack), 1);
        chk("resume_valid", 32'(rd_valid), 0);
        chk("resume_vazio", 32'(buffer_vazio), 1);
        tick(); #1;
        chk("resume_bank_a", 32'(rd_dado_a), 32'h5555);
        chk("resume_bank_b", 32'(rd_dado_b), 32'h1234);
        rd_req = 1'b0;

        // Fill under reads, then reset mid-sequence
        tick();
        wr_req = 1'b1; wr_addr = 6'd20; wr_dado = 16'hDEAD;
        rd_req = 1'b1; rd_addr_a = 6'd20; rd_addr_b = 6'd21;
        #1;
        chk("v0_wr_ack", 32'(wr_ack), 1);
        chk("v0_rd_ack", 32'(rd_ack), 1);
        tick(); wr_addr = 6'd21; wr_dado = 16'hBEEF; #1;
        chk("v1_wr_ack", 32'(wr_ack), 1);
        chk("v1_rd_ack", 32'(rd_ack), 1);
        tick(); wr_addr = 6'd22; wr_dado = 16'h7777; #1;
        chk("v2_full_wr_ack", 32'(wr_ack), 0);
        chk("v2_rw", 32'(banco_RW), 1);
        chk("v2_regC", 32'(banco_regC), 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vazio", 32'(buffer_vazio), 1);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_rw", 32'(banco_RW), 0);
        chk("mid_rst_rd_ack", 32'(rd_ack), 0);
        chk("mid_rst_wr_ack", 32'(wr_ack), 0);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_rw", 32'(banco_RW), 0);
            tick();
        end
        rd_req = 1'b1; rd_addr_a = 6'd20; rd_addr_b = 6'd21; #1;
        chk("post_rst_rd_ack", 32'(rd_ack), 1);
        tick(); rd_req = 1'b0; #1;
        chk("discard_a", 32'(rd_dado_a), 32'hB014);
        chk("discard_b", 32'(rd_dado_b), 32'hB015);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
